// File: rtl/meas_seq_ctrl_pkg.sv
// Shared definitions for the measurement-chain sequencer: state encoding,
// counter width and the default per-phase timeout.
package meas_seq_ctrl_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_ONE      = 8'd1;
    localparam logic [CNT_W-1:0] TO_TICKS_DEF = 8'd200;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MEAS  = 3'd1;
    localparam logic [2:0] S_CONV1 = 3'd2;
    localparam logic [2:0] S_CONV2 = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_MEAS  = S_MEAS,
        ST_CONV1 = S_CONV1,
        ST_CONV2 = S_CONV2,
        ST_DONE  = S_DONE,
        ST_ERR   = S_ERR
    } state_e;

endpackage

// File: rtl/meas_seq_ctrl_timer.sv
// Tick counter: counts ce pulses, flags hit on the ce that reaches limit-1 and
// wraps to 0. clear holds it at 0. hit does not depend on clear so the FSM may
// derive clear from its own next state without a combinational loop.
module seq_tick_timer
    import meas_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             ce_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last;

    assign last  = limit_i - CNT_ONE;
    assign hit_o = ce_i && (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (ce_i) begin
            cnt_d = hit_o ? '0 : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/meas_seq_ctrl.sv
// Sequencer for measurement core -> (BIN16->DEC4 || fraction) -> BIN32->DEC8,
// with manual/auto start, one queued request, per-phase timeout and a result strobe.
module meas_seq_ctrl
    import meas_seq_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] TO_TICKS = TO_TICKS_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ce10ms,
    input  logic             btn_st,
    input  logic             auto_en,
    input  logic [CNT_W-1:0] period,
    output logic             st_mes,
    input  logic             ok_mes,
    output logic             st_q,
    input  logic             ok_q,
    output logic             st_f,
    input  logic             ok_f,
    output logic             st_fd,
    input  logic             ok_fd,
    output logic             res_stb,
    output logic             busy,
    output logic             err_to,
    output logic             pend,
    output logic [CNT_W-1:0] n_done
);

    state_e           state_q, state_d;
    logic             fq_q, fq_d, ff_q, ff_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ndone_q, ndone_d;
    logic             st_mes_q, st_mes_d;
    logic             st_qf_q, st_qf_d;
    logic             st_fd_q, st_fd_d;
    logic             res_q, res_d;
    logic             busy_q, busy_d;

    logic auto_run, auto_hit, auto_tick;
    logic waiting_q, phase_clear, to_hit, req_ext;

    assign auto_run  = auto_en && (period != '0);
    assign auto_tick = auto_hit && auto_run;

    seq_tick_timer u_auto_tmr (
        .clk     (clk),
        .rst     (rst),
        .clear_i (!auto_run),
        .ce_i    (ce10ms),
        .limit_i (period),
        .hit_o   (auto_hit)
    );

    // The phase timer restarts on every state change, so each wait phase gets its own budget.
    assign waiting_q   = (state_q == ST_MEAS) || (state_q == ST_CONV1) || (state_q == ST_CONV2);
    assign phase_clear = !waiting_q || (state_d != state_q);

    seq_tick_timer u_phase_tmr (
        .clk     (clk),
        .rst     (rst),
        .clear_i (phase_clear),
        .ce_i    (ce10ms),
        .limit_i (TO_TICKS),
        .hit_o   (to_hit)
    );

    assign req_ext = btn_st || auto_tick;

    always_comb begin
        state_d  = state_q;
        fq_d     = fq_q;
        ff_d     = ff_q;
        pend_d   = pend_q;
        err_d    = err_q;
        ndone_d  = ndone_q;
        st_mes_d = 1'b0;
        st_qf_d  = 1'b0;
        st_fd_d  = 1'b0;
        res_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_ext || pend_q) begin
                    state_d  = ST_MEAS;
                    st_mes_d = 1'b1;
                    pend_d   = pend_q && req_ext;
                    err_d    = 1'b0;
                end
            end
            ST_MEAS: begin
                if (ok_mes) begin
                    state_d = ST_CONV1;
                    st_qf_d = 1'b1;
                end else if (to_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_CONV1: begin
                fq_d = fq_q || ok_q;
                ff_d = ff_q || ok_f;
                if (fq_d && ff_d) begin
                    state_d = ST_CONV2;
                    st_fd_d = 1'b1;
                    fq_d    = 1'b0;
                    ff_d    = 1'b0;
                end else if (to_hit && !ok_q && !ok_f) begin
                    state_d = ST_ERR;
                    fq_d    = 1'b0;
                    ff_d    = 1'b0;
                end
            end
            ST_CONV2: begin
                if (ok_fd) begin
                    state_d = ST_DONE;
                    res_d   = 1'b1;
                    ndone_d = ndone_q + CNT_ONE;
                end else if (to_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Requests arriving while a sequence runs collapse into one pending start.
        if ((state_q != ST_IDLE) && req_ext) begin
            pend_d = 1'b1;
        end
        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            fq_q     <= 1'b0;
            ff_q     <= 1'b0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            ndone_q  <= '0;
            st_mes_q <= 1'b0;
            st_qf_q  <= 1'b0;
            st_fd_q  <= 1'b0;
            res_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fq_q     <= fq_d;
            ff_q     <= ff_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            ndone_q  <= ndone_d;
            st_mes_q <= st_mes_d;
            st_qf_q  <= st_qf_d;
            st_fd_q  <= st_fd_d;
            res_q    <= res_d;
            busy_q   <= busy_d;
        end
    end

    assign st_mes  = st_mes_q;
    assign st_q    = st_qf_q;
    assign st_f    = st_qf_q;
    assign st_fd   = st_fd_q;
    assign res_stb = res_q;
    assign busy    = busy_q;
    assign err_to  = err_q;
    assign pend    = pend_q;
    assign n_done  = ndone_q;

endmodule

// File: doc/meas_seq_ctrl.md
# meas_seq_ctrl

Sequencer for the frequency/period measurement chain: measurement core, then the BIN16→DEC4 and fraction-to-decimal converters in parallel, then the BIN32→DEC8 converter. Accepts manual (debounced button) or periodic automatic start requests and issues one-cycle start pulses to each stage in order. Waits for each stage's done pulse and guards every phase with a timeout. Signals completion or failure to the top level, which uses the result strobe to latch UART-readable result registers.

## Interface
Parameters:
- TO_TICKS, 200: per-phase timeout in ce10ms ticks (2 s); 8-bit range 1..255.

Ports:
- clk  in  1  system clock (BUFG 50 MHz).
- rst  in  1  synchronous, active-high reset.
- ce10ms  in  1  one-cycle tick every 10 ms.
- btn_st  in  1  one-cycle manual start request (debounced BTN).
- auto_en  in  1  enable periodic auto-start.
- period  in  8  auto period in ce10ms ticks; 0 disables auto requests.
- st_mes  out  1  start pulse to measurement core.
- ok_mes  in  1  measurement-complete pulse (divider ok).
- st_q  out  1  start pulse to BIN16→DEC4.
- ok_q  in  1  BIN16→DEC4 done pulse.
- st_f  out  1  start pulse to fraction converter.
- ok_f  in  1  fraction converter done pulse.
- st_fd  out  1  start pulse to BIN32→DEC8.
- ok_fd  in  1  BIN32→DEC8 done pulse.
- res_stb  out  1  one-cycle pulse: all results valid, latch them.
- busy  out  1  high whenever state ≠ IDLE.
- err_to  out  1  sticky timeout flag.
- pend  out  1  one queued start request is waiting.
- n_done  out  8  count of successful sequences; wraps 255→0.

## Operation
- States: IDLE, MEAS, CONV1, CONV2, DONE, ERR.
- Request = btn_st, or an auto tick. A set pend also counts as a request in IDLE.
- Auto tick: the period counter counts ce10ms while auto_en=1 and period≠0. When it reaches period−1 on a ce10ms, it emits the tick and returns to 0. The counter is held at 0 when auto_en=0 or period=0. It free-runs regardless of state.
- IDLE + request → MEAS. st_mes=1 for exactly one cycle. pend cleared. err_to cleared.
- Request while not in IDLE → pend=1. Multiple requests collapse into one. A request in the same cycle that pend is consumed re-sets pend.
- MEAS: ok_mes → CONV1. st_q=1 and st_f=1 for the same single cycle.
- CONV1: internal flags capture ok_q and ok_f in either order, including in the same cycle. Once both are captured → CONV2 with st_fd=1 for one cycle. Flags clear on leaving CONV1.
- CONV2: ok_fd → DONE.
- DONE: res_stb=1 for one cycle, n_done increments, → IDLE.
- Timeout: the phase tick counter resets on entry to MEAS, CONV1 and CONV2, and increments on ce10ms. When it reaches TO_TICKS with no awaited ok in that cycle → ERR. An ok in the same cycle wins.
- ERR: err_to←1. No res_stb, no n_done change. → IDLE next cycle. err_to stays set until the next accepted start.
- ok_* pulses are accepted during their waiting state, including the cycle the corresponding st_* is high. They are ignored in every other state.
- Reset: state IDLE; st_*, res_stb, busy, err_to, pend = 0; n_done = 0; both counters 0; CONV1 flags 0.
- Reset mid-sequence aborts without further st_* pulses. Late ok_* pulses from downstream are then ignored.

## Timing
- All outputs are registered.
- Request sampled at edge N in IDLE → st_mes high in cycle N+1, busy high from N+1.
- Awaited ok sampled at edge M → next stage's st_* high in cycle M+1.
- ok_fd at edge L → res_stb high cycle L+1 → IDLE from L+2.
- With pend=1, st_mes is high in cycle L+3.
- Sequence overhead beyond stage latencies: 4 cycles plus 1 cycle of DONE.
- Timeout resolution is one ce10ms tick; the effective timeout is TO_TICKS−1 to TO_TICKS ticks after phase entry.

## Structure
- Shared package: state encoding localparams (3-bit), TO_TICKS default, counter width constant (8).
- Sub-module seq_tick_timer (clear, ce, limit → hit), instantiated twice: auto-period timer and phase timeout timer.
- Remainder: one FSM plus CONV1 flag and status registers.

## Test plan
- btn_st at cycle 10; ok_mes 50 cycles later; ok_q/ok_f same cycle; ok_fd 30 cycles later → one pulse each of st_mes, st_q+st_f, st_fd, then res_stb; n_done=1; busy low afterwards.
- ok_f 5 cycles before ok_q in CONV1 → st_fd exactly 1 cycle after ok_q; no early st_fd.
- TO_TICKS=3, ok_mes withheld, ce10ms every 20 cycles → ERR after 3 ticks; err_to=1; no res_stb. The next btn_st clears err_to and pulses st_mes.
- Three btn_st pulses during MEAS → pend=1. After res_stb, exactly one extra sequence starts at L+3. n_done reaches 2.
- auto_en=1, period=4 → st_mes every 4 ce10ms ticks while sequences finish fast. With period=0 → no st_mes.
- rst asserted in CONV2, then ok_fd arrives → outputs at reset values; no res_stb; state stays IDLE.
